regfile_write_arbiter: RTL and testbench

//  Shares the single register-file write port (write/rd/dataIn) between two writeback

---
 rtl/regfile_write_arbiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single register-file write port between two writeback
// requesters: A (load-return path) and B (ALU-result path). Each requester
// has a one-entry buffer behind a valid/ready handshake. At most one write
// is issued per cycle. Two pending writes to the same register retire in
// acceptance order. A starvation counter guarantees that B is not held off
// by A for more than STARVE_LIMIT consecutive cycles.
//
// Writes to register 0 are granted and dropped; they never reach the
// register file.
//
// Read side:
//   - Default build: rd_dataN = rf_doutN, and rsN_busy flags a register
//     that still has a buffered, unwritten value.
//   - REGFILE_ARB_BYPASS_EN defined: rd_dataN forwards the newest buffered
//     value for rsN, and both busy flags are tied low.
//   - In both builds, rsN == 0 reads as zero.
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              CLK,
    input  logic              RST,
    // requester A: load-return path
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    // requester B: ALU-result path
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    // register-file write port
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_data,
    // register-file read ports and datapath-side read data
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [DATA_W-1:0] rf_dout1,
    input  logic [DATA_W-1:0] rf_dout2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rs1_busy,
    output logic              rs2_busy
);

    // Counter wide enough to hold STARVE_LIMIT itself.
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } grant_e;

    wb_entry_t        buf_a;
    wb_entry_t        buf_b;
    logic [CNT_W-1:0] starve_cnt;
    // High when the pending B entry was accepted before the pending A entry.
    logic             b_older;

    grant_e           grant;
    logic             grant_a;
    logic             grant_b;
    logic             a_load;
    logic             b_load;
    logic             a_keep;
    logic             b_keep;
    logic             same_rd;

    assign same_rd = (buf_a.rd == buf_b.rd);
    assign grant_a = (grant == GNT_A);
    assign grant_b = (grant == GNT_B);

    // A buffer can take a new entry when it is empty or is draining this cycle.
    assign a_ready = !buf_a.v || grant_a;
    assign b_ready = !buf_b.v || grant_b;
    assign a_load  = a_valid && a_ready;
    assign b_load  = b_valid && b_ready;

    // An entry that stays pending across the coming edge.
    assign a_keep  = buf_a.v && !grant_a;
    assign b_keep  = buf_b.v && !grant_b;

    // Grant selection: ordering hazard first, then starvation relief, then A priority.
    always_comb begin
        grant = GNT_NONE;
        if (buf_a.v && buf_b.v) begin
            if (same_rd) begin
                grant = b_older ? GNT_B : GNT_A;
            end else if (starve_cnt == CNT_MAX) begin
                grant = GNT_B;
            end else begin
                grant = GNT_A;
            end
        end else if (buf_a.v) begin
            grant = GNT_A;
        end else if (buf_b.v) begin
            grant = GNT_B;
        end
    end

    // Drive the register-file write port from the granted entry; rd==0 is dropped.
    always_comb begin
        rf_write = 1'b0;
        rf_rd    = '0;
        rf_data  = '0;
        case (grant)
            GNT_A: begin
                rf_write = (buf_a.rd != '0);
                rf_rd    = buf_a.rd;
                rf_data  = buf_a.data;
            end
            GNT_B: begin
                rf_write = (buf_b.rd != '0);
                rf_rd    = buf_b.rd;
                rf_data  = buf_b.data;
            end
            default: begin
                rf_write = 1'b0;
            end
        endcase
    end

    // Buffer A: load on handshake, otherwise clear when its entry is granted.
    // NOTE: only the valid bit is reset; rd/data are qualified by it, so clearing
    //       them would add reset fan-out on wide fields for no functional gain.
    always_ff @(posedge CLK) begin
        if (RST) begin
            buf_a.v <= 1'b0;
        end else if (a_load) begin
            buf_a <= '{v: 1'b1, rd: a_rd, data: a_data};
        end else if (grant_a) begin
            buf_a.v <= 1'b0;
        end
    end

    // Buffer B: same behaviour as buffer A.
    always_ff @(posedge CLK) begin
        if (RST) begin
            buf_b.v <= 1'b0;
        end else if (b_load) begin
            buf_b <= '{v: 1'b1, rd: b_rd, data: b_data};
        end else if (grant_b) begin
            buf_b.v <= 1'b0;
        end
    end

    // Age tracking so that same-register writes retire in acceptance order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            b_older <= 1'b0;
        end else if (a_load && b_load) begin
            // Simultaneous acceptance: A counts as the older entry.
            b_older <= 1'b0;
        end else if (a_load && b_keep) begin
            // A arrives behind a still-pending B entry.
            b_older <= 1'b1;
        end else if (b_load && a_keep) begin
            // B arrives behind a still-pending A entry.
            b_older <= 1'b0;
        end
    end

    // Starvation counter: consecutive cycles a pending B entry lost to A.
    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt <= '0;
        end else if (grant_b || !buf_b.v) begin
            starve_cnt <= '0;
        end else if (grant_a && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

`ifdef REGFILE_ARB_BYPASS_EN

    // Newest buffered value for rs, else the register-file value; rs==0 reads zero.
    function automatic logic [DATA_W-1:0] fwd_read(
        input logic [ADDR_W-1:0] rs,
        input logic [DATA_W-1:0] dout,
        input wb_entry_t         ea,
        input wb_entry_t         eb,
        input logic              eb_older
    );
        logic hit_a;
        logic hit_b;
        hit_a = ea.v && (ea.rd == rs);
        hit_b = eb.v && (eb.rd == rs);
        if (rs == '0) begin
            fwd_read = '0;
        end else if (hit_a && hit_b) begin
            fwd_read = eb_older ? ea.data : eb.data;
        end else if (hit_a) begin
            fwd_read = ea.data;
        end else if (hit_b) begin
            fwd_read = eb.data;
        end else begin
            fwd_read = dout;
        end
    endfunction

    // Forwarded read data; nothing is ever stale, so busy never asserts.
    always_comb begin
        rd_data1 = fwd_read(rs1, rf_dout1, buf_a, buf_b, b_older);
        rd_data2 = fwd_read(rs2, rf_dout2, buf_a, buf_b, b_older);
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
    end

`else

    // Register rs has a buffered value that the register file does not hold yet.
    function automatic logic pending_hit(
        input logic [ADDR_W-1:0] rs,
        input wb_entry_t         ea,
        input wb_entry_t         eb
    );
        pending_hit = (rs != '0) &&
                      ((ea.v && (ea.rd == rs)) || (eb.v && (eb.rd == rs)));
    endfunction

    // Plain read-through with hazard flags; rs==0 reads zero.
    always_comb begin
        rd_data1 = (rs1 == '0) ? '0 : rf_dout1;
        rd_data2 = (rs2 == '0) ? '0 : rf_dout2;
        rs1_busy = pending_hit(rs1, buf_a, buf_b);
        rs2_busy = pending_hit(rs2, buf_a, buf_b);
    end

`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for regfile_write_arbiter. A small behavioural register
// file sits on the write port so that final register contents can be checked.
// Expectations follow the build: define REGFILE_ARB_BYPASS_EN for both DUT
// and bench to exercise the forwarding configuration.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

`ifdef REGFILE_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              CLK;
    logic              RST;
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_rd;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_rd;
    logic [DATA_W-1:0] b_data;
    logic              rf_write;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_data;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] rf_dout1;
    logic [DATA_W-1:0] rf_dout2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rs1_busy;
    logic              rs2_busy;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] regs [32];

    regfile_write_arbiter #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .STARVE_LIMIT(3)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_rd    (a_rd),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_rd    (b_rd),
        .b_data  (b_data),
        .rf_write(rf_write),
        .rf_rd   (rf_rd),
        .rf_data (rf_data),
        .rs1     (rs1),
        .rs2     (rs2),
        .rf_dout1(rf_dout1),
        .rf_dout2(rf_dout2),
        .rd_data1(rd_data1),
        .rd_data2(rd_data2),
        .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural register file on the arbiter's write port.
    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (rf_write) begin
            regs[rf_rd] <= rf_data;
        end
    end

    assign rf_dout1 = regs[rs1];
    assign rf_dout2 = regs[rs2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable for sampling.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST     = 1'b1;
        a_valid = 1'b1;
        a_rd    = 5'd3;
        a_data  = 32'hDEAD_0003;
        b_valid = 1'b1;
        b_rd    = 5'd4;
        b_data  = 32'hDEAD_0004;
        rs1     = 5'd3;
        rs2     = 5'd4;

        // ---- reset held two cycles with both requesters valid ----
        tick();
        tick();
        check("rst_rf_write", 64'(rf_write), 64'd0);
        check("rst_a_ready",  64'(a_ready),  64'd1);
        check("rst_b_ready",  64'(b_ready),  64'd1);
        RST     = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        check("rst_rs1_busy", 64'(rs1_busy), 64'd0);
        tick();
        check("idle_rf_write", 64'(rf_write), 64'd0);
        check("idle_a_ready",  64'(a_ready),  64'd1);
        check("idle_b_ready",  64'(b_ready),  64'd1);

        // ---- single A write to r5 ----
        a_valid = 1'b1;
        a_rd    = 5'd5;
        a_data  = 32'h11;
        rs1     = 5'd5;
        tick();
        a_valid = 1'b0;
        #1;
        check("a5_rf_write", 64'(rf_write), 64'd1);
        check("a5_rf_rd",    64'(rf_rd),    64'd5);
        check("a5_rf_data",  64'(rf_data),  64'h11);
        check("a5_busy",     64'(rs1_busy), BYP ? 64'd0 : 64'd1);
        check("a5_rd_data1", 64'(rd_data1), BYP ? 64'h11 : 64'h0);
        tick();
        check("a5_post_rf_write", 64'(rf_write), 64'd0);
        check("a5_post_busy",     64'(rs1_busy), 64'd0);
        check("a5_post_rd_data1", 64'(rd_data1), 64'h11);

        // ---- A write to r0 is accepted and dropped ----
        a_valid = 1'b1;
        a_rd    = 5'd0;
        a_data  = 32'hFF;
        rs1     = 5'd0;
        tick();
        a_valid = 1'b0;
        #1;
        check("r0_rf_write", 64'(rf_write), 64'd0);
        check("r0_a_ready",  64'(a_ready),  64'd1);
        check("r0_busy",     64'(rs1_busy), 64'd0);
        check("r0_rd_data1", 64'(rd_data1), 64'd0);
        tick();
        check("r0_post_rf_write", 64'(rf_write), 64'd0);
        check("r0_post_a_ready",  64'(a_ready),  64'd1);

        // ---- B to r7, then A to r7 the following cycle ----
        b_valid = 1'b1;
        b_rd    = 5'd7;
        b_data  = 32'h22;
        rs2     = 5'd7;
        tick();
        b_valid = 1'b0;
        a_valid = 1'b1;
        a_rd    = 5'd7;
        a_data  = 32'h33;
        #1;
        check("r7_first_write", 64'(rf_write), 64'd1);
        check("r7_first_rd",    64'(rf_rd),    64'd7);
        check("r7_first_data",  64'(rf_data),  64'h22);
        check("r7_busy2",       64'(rs2_busy), BYP ? 64'd0 : 64'd1);
        check("r7_rd_data2",    64'(rd_data2), BYP ? 64'h22 : 64'h0);
        tick();
        a_valid = 1'b0;
        #1;
        check("r7_second_write", 64'(rf_write), 64'd1);
        check("r7_second_data",  64'(rf_data),  64'h33);
        tick();
        check("r7_final", 64'(regs[7]), 64'h33);
        check("r7_done_write", 64'(rf_write), 64'd0);

        // ---- same register pending in both buffers: older (B) retires first ----
        a_valid = 1'b1;
        a_rd    = 5'd1;
        a_data  = 32'hA1;
        b_valid = 1'b1;
        b_rd    = 5'd2;
        b_data  = 32'hB2;
        rs1     = 5'd2;
        tick();
        // A wins (no conflict, B not starved); A reloads targeting r2 behind B.
        b_valid = 1'b0;
        a_rd    = 5'd2;
        a_data  = 32'hA2;
        #1;
        check("ord_first_rd",   64'(rf_rd),   64'd1);
        check("ord_first_data", 64'(rf_data), 64'hA1);
        check("ord_b_ready",    64'(b_ready), 64'd0);
        tick();
        a_valid = 1'b0;
        #1;
        check("ord_second_rd",   64'(rf_rd),    64'd2);
        check("ord_second_data", 64'(rf_data),  64'hB2);
        check("ord_busy1",       64'(rs1_busy), BYP ? 64'd0 : 64'd1);
        check("ord_rd_data1",    64'(rd_data1), BYP ? 64'hA2 : 64'h0);
        tick();
        check("ord_third_data", 64'(rf_data), 64'hA2);
        tick();
        check("ord_final_r2", 64'(regs[2]), 64'hA2);
        check("ord_final_r1", 64'(regs[1]), 64'hA1);

        // ---- both valid every cycle: A,A,A,B repeating ----
        a_valid = 1'b1;
        a_rd    = 5'd10;
        a_data  = 32'hAA;
        b_valid = 1'b1;
        b_rd    = 5'd20;
        b_data  = 32'hBB;
        tick();
        for (int i = 0; i < 12; i++) begin
            check($sformatf("starve_rd_%0d", i), 64'(rf_rd),
                  ((i % 4) == 3) ? 64'd20 : 64'd10);
            check($sformatf("starve_b_ready_%0d", i), 64'(b_ready),
                  ((i % 4) == 3) ? 64'd1 : 64'd0);
            tick();
        end

        // ---- reset while both buffers hold entries ----
        check("pre_rst_b_ready", 64'(b_ready), 64'd0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        RST     = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        check("mid_rst_rf_write", 64'(rf_write), 64'd0);
        check("mid_rst_a_ready",  64'(a_ready),  64'd1);
        check("mid_rst_b_ready",  64'(b_ready),  64'd1);
        tick();
        check("mid_rst_post_write", 64'(rf_write), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
